// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared entry type, counter constants and counter helper for the branch predictor
package bp_pkg;

    localparam int BP_INDEX_W = 6;
    localparam int BP_TAG_W   = 8;

    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        logic [1:0]          cnt;
    } bp_entry_t;

    function automatic logic [1:0] sat_cnt2(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bp_table.sv
// rtl/bp_table.sv - BTB/BHT flop array, two async read ports, two training ports (b wins on collision)
module bp_table
    import bp_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_idx_a,
    input  logic [INDEX_W-1:0]  rd_idx_b,
    output bp_entry_t           rd_entry_a,
    output bp_entry_t           rd_entry_b,
    input  logic                upd_valid_a,
    input  logic [INDEX_W-1:0]  upd_idx_a,
    input  logic [BP_TAG_W-1:0] upd_tag_a,
    input  logic                upd_taken_a,
    input  logic [31:0]         upd_target_a,
    input  logic                upd_valid_b,
    input  logic [INDEX_W-1:0]  upd_idx_b,
    input  logic [BP_TAG_W-1:0] upd_tag_b,
    input  logic                upd_taken_b,
    input  logic [31:0]         upd_target_b
);

    localparam int DEPTH = 1 << INDEX_W;

    bp_entry_t mem_q [DEPTH];
    bp_entry_t mem_d [DEPTH];
    bp_entry_t new_a;
    bp_entry_t new_b;
    logic      wr_a;
    logic      wr_b;

    // Returns the write enable; a not-taken miss leaves the table untouched.
    function automatic logic train(input bp_entry_t old, input logic [BP_TAG_W-1:0] tag,
                                   input logic taken, input logic [31:0] target,
                                   output bp_entry_t nxt);
        nxt = old;
        if (old.valid && (old.tag == tag)) begin
            nxt.cnt = sat_cnt2(old.cnt, taken);
            if (taken) begin
                nxt.target = target;
            end
            return 1'b1;
        end
        if (taken) begin
            nxt = '{valid: 1'b1, tag: tag, target: target, cnt: CNT_WT};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_a  = 1'b0;
        wr_b  = 1'b0;
        new_a = '0;
        new_b = '0;
        if (upd_valid_a) begin
            wr_a = train(mem_q[upd_idx_a], upd_tag_a, upd_taken_a, upd_target_a, new_a);
        end
        if (upd_valid_b) begin
            wr_b = train(mem_q[upd_idx_b], upd_tag_b, upd_taken_b, upd_target_b, new_b);
        end
        if (wr_a) begin
            mem_d[upd_idx_a] = new_a;
        end
        if (wr_b) begin
            mem_d[upd_idx_b] = new_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_entry_a = mem_q[rd_idx_a];
    assign rd_entry_b = mem_q[rd_idx_b];

endmodule

// File: rtl/br_predictor.sv
// rtl/br_predictor.sv - dual-slot branch predictor top: lookup, slot masking, target mux, output regs
module br_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W,
    parameter int TAG_W   = BP_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_valid,
    input  logic        IF_stall,
    input  logic        IF_flush,
    input  logic [31:0] IF_pc,
    output logic        PD_valid,
    output logic        PD_taken_a,
    output logic        PD_taken_b,
    output logic [31:0] PD_target,
    input  logic        UPD_valid_a,
    input  logic [31:0] UPD_pc_a,
    input  logic        UPD_taken_a,
    input  logic [31:0] UPD_target_a,
    input  logic        UPD_valid_b,
    input  logic [31:0] UPD_pc_b,
    input  logic        UPD_taken_b,
    input  logic [31:0] UPD_target_b
);

    function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[INDEX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[TAG_W+INDEX_W+1:INDEX_W+2];
    endfunction

    logic [31:0] pc_b;
    logic [31:0] pc_seq;
    bp_entry_t   ent_a;
    bp_entry_t   ent_b;
    logic        taken_a;
    logic        taken_b;
    logic [31:0] target;

    logic        pd_valid_q,   pd_valid_d;
    logic        pd_taken_a_q, pd_taken_a_d;
    logic        pd_taken_b_q, pd_taken_b_d;
    logic [31:0] pd_target_q,  pd_target_d;

    assign pc_b   = IF_pc + 32'd4;
    assign pc_seq = IF_pc + 32'd8;

    bp_table #(.INDEX_W(INDEX_W)) u_table (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_a     (pc_index(IF_pc)),
        .rd_idx_b     (pc_index(pc_b)),
        .rd_entry_a   (ent_a),
        .rd_entry_b   (ent_b),
        .upd_valid_a  (UPD_valid_a),
        .upd_idx_a    (pc_index(UPD_pc_a)),
        .upd_tag_a    (pc_tag(UPD_pc_a)),
        .upd_taken_a  (UPD_taken_a),
        .upd_target_a (UPD_target_a),
        .upd_valid_b  (UPD_valid_b),
        .upd_idx_b    (pc_index(UPD_pc_b)),
        .upd_tag_b    (pc_tag(UPD_pc_b)),
        .upd_taken_b  (UPD_taken_b),
        .upd_target_b (UPD_target_b)
    );

    always_comb begin
        taken_a = ent_a.valid && (ent_a.tag == pc_tag(IF_pc)) && ent_a.cnt[1];
        taken_b = ent_b.valid && (ent_b.tag == pc_tag(pc_b)) && ent_b.cnt[1];
        if (taken_a) begin
            target = ent_a.target;
        end else if (taken_b) begin
            target = ent_b.target;
        end else begin
            target = pc_seq;
        end
    end

    // Flush beats stall; the target is left alone whenever the prediction is dead.
    always_comb begin
        pd_valid_d   = pd_valid_q;
        pd_taken_a_d = pd_taken_a_q;
        pd_taken_b_d = pd_taken_b_q;
        pd_target_d  = pd_target_q;
        if (IF_flush || (!IF_stall && !IF_valid)) begin
            pd_valid_d   = 1'b0;
            pd_taken_a_d = 1'b0;
            pd_taken_b_d = 1'b0;
        end else if (!IF_stall) begin
            pd_valid_d   = 1'b1;
            pd_taken_a_d = taken_a;
            pd_taken_b_d = taken_b && !taken_a;
            pd_target_d  = target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pd_valid_q   <= 1'b0;
            pd_taken_a_q <= 1'b0;
            pd_taken_b_q <= 1'b0;
            pd_target_q  <= '0;
        end else begin
            pd_valid_q   <= pd_valid_d;
            pd_taken_a_q <= pd_taken_a_d;
            pd_taken_b_q <= pd_taken_b_d;
            pd_target_q  <= pd_target_d;
        end
    end

    assign PD_valid   = pd_valid_q;
    assign PD_taken_a = pd_taken_a_q;
    assign PD_taken_b = pd_taken_b_q;
    assign PD_target  = pd_target_q;

endmodule

// File: tb/tb_br_predictor.sv
// tb/tb_br_predictor.sv - self-checking bench for br_predictor with an expected-prediction queue
module tb_br_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_valid, IF_stall, IF_flush;
    logic [31:0] IF_pc;
    logic        PD_valid, PD_taken_a, PD_taken_b;
    logic [31:0] PD_target;
    logic        UPD_valid_a, UPD_taken_a, UPD_valid_b, UPD_taken_b;
    logic [31:0] UPD_pc_a, UPD_target_a, UPD_pc_b, UPD_target_b;

    int cmp_count  = 0;
    int fail_count = 0;

    logic [34:0] exp_q [$];

    br_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .IF_valid     (IF_valid),
        .IF_stall     (IF_stall),
        .IF_flush     (IF_flush),
        .IF_pc        (IF_pc),
        .PD_valid     (PD_valid),
        .PD_taken_a   (PD_taken_a),
        .PD_taken_b   (PD_taken_b),
        .PD_target    (PD_target),
        .UPD_valid_a  (UPD_valid_a),
        .UPD_pc_a     (UPD_pc_a),
        .UPD_taken_a  (UPD_taken_a),
        .UPD_target_a (UPD_target_a),
        .UPD_valid_b  (UPD_valid_b),
        .UPD_pc_b     (UPD_pc_b),
        .UPD_taken_b  (UPD_taken_b),
        .UPD_target_b (UPD_target_b)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] obs_vec();
        return {PD_valid, PD_taken_a, PD_taken_b, PD_target};
    endfunction

    task automatic clear_inputs();
        IF_valid = 1'b0; IF_stall = 1'b0; IF_flush = 1'b0; IF_pc = '0;
        UPD_valid_a = 1'b0; UPD_pc_a = '0; UPD_taken_a = 1'b0; UPD_target_a = '0;
        UPD_valid_b = 1'b0; UPD_pc_b = '0; UPD_taken_b = 1'b0; UPD_target_b = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_lookup(input logic [31:0] pc, input logic ta, input logic tb,
                                input logic [31:0] tgt);
        IF_valid = 1'b1;
        IF_pc    = pc;
        exp_q.push_back({1'b1, ta, tb, tgt});
    endtask

    task automatic set_upd(input logic port_b, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt);
        if (port_b) begin
            UPD_valid_b = 1'b1; UPD_pc_b = pc; UPD_taken_b = taken; UPD_target_b = tgt;
        end else begin
            UPD_valid_a = 1'b1; UPD_pc_a = pc; UPD_taken_a = taken; UPD_target_a = tgt;
        end
    endtask

    task automatic pop_exp(output logic [34:0] e, output logic ok);
        ok = (exp_q.size() != 0);
        e  = ok ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        cmp_count++;
        if (obs_vec() !== 35'd0) begin
            fail_count++;
            $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 35'd0);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_lookup();
        logic [34:0] e; logic ok;
        drive_lookup(32'h1c000000, 1'b0, 1'b0, 32'h1c000008);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL first_lookup: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_train();
        logic [34:0] e; logic ok;
        set_upd(1'b0, 32'h1c000000, 1'b1, 32'h1c000100);
        step();
        clear_inputs();
        drive_lookup(32'h1c000000, 1'b1, 1'b0, 32'h1c000100);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL train_alloc: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_slot_b();
        logic [34:0] e; logic ok;
        repeat (2) begin
            set_upd(1'b1, 32'h1c000004, 1'b1, 32'h1c000200);
            step();
            clear_inputs();
        end
        drive_lookup(32'h1c000000, 1'b1, 1'b0, 32'h1c000100);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL slot_b_masked: got %h expected %h", obs_vec(), e);
        end
        set_upd(1'b0, 32'h1c000000, 1'b0, 32'h0);
        step();
        clear_inputs();
        drive_lookup(32'h1c000000, 1'b0, 1'b1, 32'h1c000200);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL slot_b_taken: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_saturation();
        logic [34:0] e; logic ok;
        logic        upd_tk [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        exp_tk [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] tgt;
        for (int i = 0; i < 9; i++) begin
            tgt = (i == 8) ? 32'h1c000500 : 32'h1c000400;
            set_upd(1'b0, 32'h1c000040, upd_tk[i], tgt);
            step();
            clear_inputs();
            drive_lookup(32'h1c000040, exp_tk[i], 1'b0, exp_tk[i] ? tgt : 32'h1c000048);
            step();
            IF_valid = 1'b0;
            pop_exp(e, ok);
            cmp_count++;
            if (!ok || obs_vec() !== e) begin
                fail_count++;
                $display("FAIL sat_counter step %0d: got %h expected %h", i, obs_vec(), e);
            end
        end
    endtask

    task automatic test_collision();
        logic [34:0] e; logic ok;
        set_upd(1'b0, 32'h1c000080, 1'b1, 32'h00000100);
        set_upd(1'b1, 32'h1c000080, 1'b1, 32'h00000200);
        drive_lookup(32'h1c000080, 1'b0, 1'b0, 32'h1c000088);
        step();
        clear_inputs();
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL read_during_write: got %h expected %h", obs_vec(), e);
        end
        drive_lookup(32'h1c000080, 1'b1, 1'b0, 32'h00000200);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL collision_b_wins: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_stall_flush();
        logic [34:0] e; logic ok;
        drive_lookup(32'h1c000000, 1'b0, 1'b1, 32'h1c000200);
        step();
        pop_exp(e, ok);
        IF_stall = 1'b1;
        IF_pc    = 32'h1c000040;
        exp_q.push_back(e);
        set_upd(1'b0, 32'h1c0000c0, 1'b1, 32'h1c000600);
        step();
        clear_inputs();
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL stall_hold: got %h expected %h", obs_vec(), e);
        end
        IF_valid = 1'b1; IF_stall = 1'b1; IF_flush = 1'b1; IF_pc = 32'h1c000040;
        exp_q.push_back(35'd0);
        step();
        clear_inputs();
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() >> 32 !== e >> 32) begin
            fail_count++;
            $display("FAIL flush_over_stall: got %h expected %h", obs_vec() >> 32, e >> 32);
        end
        exp_q.push_back(35'd0);
        step();
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() >> 32 !== e >> 32) begin
            fail_count++;
            $display("FAIL idle_invalid: got %h expected %h", obs_vec() >> 32, e >> 32);
        end
        drive_lookup(32'h1c0000c0, 1'b1, 1'b0, 32'h1c000600);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL train_during_stall: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_reset_mid();
        logic [34:0] e; logic ok;
        drive_lookup(32'h1c000080, 1'b1, 1'b0, 32'h00000200);
        step();
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        cmp_count++;
        if (obs_vec() !== 35'd0) begin
            fail_count++;
            $display("FAIL reset_mid_outputs: got %h expected %h", obs_vec(), 35'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        drive_lookup(32'h1c000080, 1'b0, 1'b0, 32'h1c000088);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL reset_mid_miss: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_wrap();
        logic [34:0] e; logic ok;
        drive_lookup(32'hfffffff8, 1'b0, 1'b0, 32'h00000000);
        step();
        IF_valid = 1'b0;
        pop_exp(e, ok);
        cmp_count++;
        if (!ok || obs_vec() !== e) begin
            fail_count++;
            $display("FAIL target_wrap: got %h expected %h", obs_vec(), e);
        end
    endtask

    initial begin
        test_reset();
        test_first_lookup();
        test_train();
        test_slot_b();
        test_saturation();
        test_collision();
        test_stall_flush();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
